mem_bank_reader: RTL and testbench
==================================

# mem_bank_reader

Read-side companion to the `mem_i_j` register bank written by `addr_i`/`addr_j` decode. On a `start` pulse it scans all ROWS×COLS entries in row-major order, row outer and column inner. Each entry is presented on a valid/ready output stream with its row/column tag and a last flag. It sits between the bank and the downstream serializer or host readout path.

## Interface
Parameters:
- ROWS, default 4: number of rows (i index), ≥1.
- COLS, default 3: number of columns (j index), ≥1.
- DW, default 8: entry width in bits.
- RW, default max($clog2(ROWS),1): row tag width (derived).
- CW, default max($clog2(COLS),1): column tag width (derived).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_flat  in  ROWS*COLS*DW  flattened bank; entry (i,j) is at [(i*COLS+j)*DW +: DW].
- start  in  1  scan request; sampled in IDLE only.
- abort  in  1  synchronous scan cancel.
- dout_ready  in  1  downstream accept.
- dout  out  DW  entry data.
- dout_valid  out  1  beat valid.
- dout_row  out  RW  row tag i.
- dout_col  out  CW  column tag j.
- dout_last  out  1  high on entry (ROWS-1,COLS-1).
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States: IDLE and SCAN.
- IDLE → SCAN when start=1 and abort=0. Row/col counters load 0 and the first beat is loaded.
- In SCAN, on a handshake (dout_valid && dout_ready):
  - If not last: col increments. When col reaches COLS-1 it wraps to 0 and row increments. The next entry loads and dout_valid stays high, so there is no bubble.
  - If last: go to IDLE, dout_valid=0, done=1 on the next cycle.
- Without a handshake, dout, dout_row, dout_col and dout_last hold stable while dout_valid=1.
- abort=1 in SCAN: go to IDLE on the next edge. dout_valid=0, no done pulse. abort has priority over a same-cycle handshake.
- start while in SCAN is ignored. start in the same cycle as the done pulse is accepted, because the state is already IDLE.
- A beat's data is the mem_flat entry as of the clock edge that loads the beat. See Configuration for snapshot mode.
- busy = (state==SCAN).
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-scan drops dout_valid immediately (asynchronous) and no done pulse is produced.

## Timing
- start sampled at edge N → dout_valid=1 with entry (0,0) after edge N, i.e. in cycle N+1.
- Continuous dout_ready=1: beat k is in cycle N+1+k, for k = 0..ROWS*COLS-1. done=1 in cycle N+1+ROWS*COLS.
- Full scan with no backpressure: ROWS*COLS+1 cycles from start to done.
- Every output is registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: MEM_BANK_READER_SNAPSHOT_EN.
- Defined: the whole mem_flat is captured into an internal ROWS*COLS*DW register on the start edge. All beats come from that snapshot, so bank writes during a scan never appear in the output.
- Undefined: no snapshot storage. Each beat samples live mem_flat at its load edge, so a write landing before an entry's load edge is visible in that entry.

## Test plan
- Defaults, entry (i,j) = 8'h{i}{j}, dout_ready=1, start pulse → 12 beats in consecutive cycles: 00, 01, 02, 10 … 32. dout_last only on 32. done one cycle after beat 32. busy high for exactly 12 cycles.
- dout_ready toggling 1,0,0,1,… → each beat held stable through ready=0 cycles. Order and values unchanged, no beat dropped or duplicated.
- start pulsed again mid-scan → ignored; sequence completes normally. start in the done cycle → new scan begins next cycle with beat 00.
- abort while beat (1,2) is valid → dout_valid=0 the next cycle, busy=0, done never asserts. A following start rescans from (0,0).
- rst_n low while beat (2,1) is valid → outputs zero immediately. After release: IDLE, and no output until start.
- Entry (3,2) rewritten from 32 to AA while beat (0,1) is valid → with snapshot enabled, the last beat is 32; without it, the last beat is AA.

Source files
------------

// File: rtl/mem_bank_reader_if.sv
// mem_bank_reader_if
//   Groups the bank input, the scan control and the entry output stream of
//   mem_bank_reader.
//   master : the reader itself (samples bank and control, drives the stream)
//   slave  : the bank/host side (drives bank and control, consumes the stream)
//   Signals:
//     mem_flat   ROWS*COLS*DW  flattened bank, entry (i,j) at [(i*COLS+j)*DW +: DW]
//     start      scan request (honoured in IDLE only)
//     abort      synchronous scan cancel
//     dout_ready downstream accept
//     dout, dout_valid, dout_row, dout_col, dout_last  entry stream
//     busy       scan in progress
//     done       one-cycle pulse after the last beat is accepted
interface mem_bank_reader_if #(
  parameter int ROWS = 4,
  parameter int COLS = 3,
  parameter int DW   = 8,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1
);
  logic [ROWS*COLS*DW-1:0] mem_flat;
  logic                    start;
  logic                    abort;
  logic                    dout_ready;
  logic [DW-1:0]           dout;
  logic                    dout_valid;
  logic [RW-1:0]           dout_row;
  logic [CW-1:0]           dout_col;
  logic                    dout_last;
  logic                    busy;
  logic                    done;

  modport master (
    input  mem_flat, start, abort, dout_ready,
    output dout, dout_valid, dout_row, dout_col, dout_last, busy, done
  );

  modport slave (
    output mem_flat, start, abort, dout_ready,
    input  dout, dout_valid, dout_row, dout_col, dout_last, busy, done
  );
endinterface

// File: rtl/mem_bank_reader.sv
// mem_bank_reader
//   Scans a ROWS x COLS register bank in row-major order (row outer, column
//   inner) and presents each entry on a valid/ready stream tagged with its
//   row/column and a last flag. All outputs are registered.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    mem_bank_reader_if.master (bank in, control in, stream out)
//   Build option:
//     MEM_BANK_READER_SNAPSHOT_EN  defined: the bank is captured on the start
//       edge and every beat comes from that copy. Undefined: each beat samples
//       the live bank on the edge that loads it.
module mem_bank_reader #(
  parameter int ROWS = 4,
  parameter int COLS = 3,
  parameter int DW   = 8,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_bank_reader_if.master   bus
);

  localparam int NBITS = ROWS * COLS * DW;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           r_state;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [DW-1:0]    r_dout;
  logic             r_valid;
  logic             r_last;
  logic             r_busy;
  logic             r_done;

  logic [NBITS-1:0] w_src;
  logic [RW-1:0]    w_nrow;
  logic [CW-1:0]    w_ncol;
  logic             w_nlast;
  logic [31:0]      w_nidx;

  function automatic logic [DW-1:0] entry_at(input logic [NBITS-1:0] src,
                                             input logic [31:0]      idx);
    return src[idx*DW +: DW];
  endfunction

`ifdef MEM_BANK_READER_SNAPSHOT_EN
  logic [NBITS-1:0] r_snap;

  // The first beat loads on the same edge that captures the snapshot, so in
  // IDLE it must come straight from the bank.
  always_comb begin
    w_src = r_snap;
    if (r_state == IDLE) w_src = bus.mem_flat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= '0;
    end else if (r_state == IDLE && bus.start && !bus.abort) begin
      r_snap <= bus.mem_flat;
    end
  end
`else
  always_comb begin
    w_src = bus.mem_flat;
  end
`endif

  // Position of the beat that follows the one currently presented.
  always_comb begin
    w_ncol = r_col + CW'(1);
    w_nrow = r_row;
    if (r_col == CW'(COLS - 1)) begin
      w_ncol = '0;
      w_nrow = r_row + RW'(1);
    end
    w_nlast = (w_nrow == RW'(ROWS - 1)) && (w_ncol == CW'(COLS - 1));
    w_nidx  = 32'(w_nrow) * COLS + 32'(w_ncol);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            r_state <= SCAN;
            r_busy  <= 1'b1;
            r_row   <= '0;
            r_col   <= '0;
            r_dout  <= entry_at(w_src, 32'd0);
            r_valid <= 1'b1;
            r_last  <= (ROWS * COLS == 1);
          end
        end
        SCAN: begin
          // abort wins over a handshake in the same cycle
          if (bus.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end else if (r_valid && bus.dout_ready) begin
            if (r_last) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_row   <= w_nrow;
              r_col   <= w_ncol;
              r_dout  <= entry_at(w_src, w_nidx);
              r_last  <= w_nlast;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.dout_row   = r_row;
  assign bus.dout_col   = r_col;
  assign bus.dout_last  = r_last;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_mem_bank_reader.sv
// tb_mem_bank_reader
//   Directed bench for mem_bank_reader at default geometry (4x3, 8-bit).
//   Bank entry (i,j) holds 8'h{i}{j}. Inputs are driven and outputs are
//   sampled 1 time unit after the rising edge.
//   Honours MEM_BANK_READER_SNAPSHOT_EN for the mid-scan bank write case.
module tb_mem_bank_reader;
  localparam int ROWS = 4;
  localparam int COLS = 3;
  localparam int DW   = 8;
  localparam int N    = ROWS * COLS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bank_reader_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) bus ();

  mem_bank_reader #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived expected entry for beat k: row k/COLS, col k%COLS -> 8'h{row}{col}
  function automatic logic [7:0] exp_data(input int k);
    return 8'(((k / COLS) << 4) | (k % COLS));
  endfunction

  task automatic fill_bank();
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        bus.mem_flat[(i*COLS + j)*DW +: DW] = 8'((i << 4) | j);
  endtask

  task automatic check_beat(input int k, input logic [7:0] data);
    check($sformatf("valid[%0d]", k), 32'(bus.dout_valid), 32'd1);
    check($sformatf("dout[%0d]", k),  32'(bus.dout), 32'(data));
    check($sformatf("row[%0d]", k),   32'(bus.dout_row), 32'(k / COLS));
    check($sformatf("col[%0d]", k),   32'(bus.dout_col), 32'(k % COLS));
    check($sformatf("last[%0d]", k),  32'(bus.dout_last), 32'(k == N-1));
    check($sformatf("busy[%0d]", k),  32'(bus.busy), 32'd1);
    check($sformatf("done[%0d]", k),  32'(bus.done), 32'd0);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Beat 0 is assumed presented; run the scan with ready=1 and check the done cycle.
  task automatic scan_all(input string tag);
    for (int k = 0; k < N; k++) begin
      check_beat(k, exp_data(k));
      tick();
    end
    check({tag, "_done"},  32'(bus.done), 32'd1);
    check({tag, "_valid"}, 32'(bus.dout_valid), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [3:0] rdy_pat;
    logic [7:0] last_exp;
    int k;
    int c;

    rdy_pat        = 4'b1001;  // cycle c uses rdy_pat[c%4]: 1,0,0,1
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.dout_ready = 1'b1;
    bus.mem_flat   = '0;
    fill_bank();

    // Reset state
    #12;
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    check("rst_dout",  32'(bus.dout), 32'd0);
    check("rst_last",  32'(bus.dout_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_valid", 32'(bus.dout_valid), 32'd0);

    // Full scan, no backpressure
    pulse_start();
    scan_all("full");

    // Backpressure with ready pattern 1,0,0,1
    pulse_start();
    k = 0;
    c = 0;
    while (k < N && c < 200) begin
      check($sformatf("bp_valid[%0d]", c), 32'(bus.dout_valid), 32'd1);
      check($sformatf("bp_dout[%0d]", c),  32'(bus.dout), 32'(exp_data(k)));
      check($sformatf("bp_row[%0d]", c),   32'(bus.dout_row), 32'(k / COLS));
      check($sformatf("bp_col[%0d]", c),   32'(bus.dout_col), 32'(k % COLS));
      check($sformatf("bp_last[%0d]", c),  32'(bus.dout_last), 32'(k == N-1));
      bus.dout_ready = rdy_pat[c % 4];
      if (bus.dout_ready) k++;
      c++;
      tick();
    end
    bus.dout_ready = 1'b1;
    check("bp_beats", 32'(k), 32'(N));
    check("bp_done", 32'(bus.done), 32'd1);
    tick();

    // start mid-scan is ignored; start in the done cycle is accepted
    pulse_start();
    for (k = 0; k < N; k++) begin
      check_beat(k, exp_data(k));
      bus.start = (k == 3);
      tick();
    end
    bus.start = 1'b0;
    check("mid_done", 32'(bus.done), 32'd1);
    pulse_start();
    check("redo_valid", 32'(bus.dout_valid), 32'd1);

    // abort while beat (1,2) is presented, with ready=1 in the same cycle
    for (k = 0; k < 5; k++) begin
      check_beat(k, exp_data(k));
      tick();
    end
    check_beat(5, exp_data(5));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_valid", 32'(bus.dout_valid), 32'd0);
    check("abort_busy",  32'(bus.busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort_nodone[%0d]", i), 32'(bus.done), 32'd0);
      check($sformatf("abort_idle[%0d]", i), 32'(bus.dout_valid), 32'd0);
      tick();
    end
    pulse_start();
    scan_all("post_abort");

    // Asynchronous reset while beat (2,1) is presented
    pulse_start();
    for (k = 0; k < 7; k++) tick();
    check_beat(7, exp_data(7));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.dout_valid), 32'd0);
    check("arst_dout",  32'(bus.dout), 32'd0);
    check("arst_row",   32'(bus.dout_row), 32'd0);
    check("arst_col",   32'(bus.dout_col), 32'd0);
    check("arst_busy",  32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("arst_idle[%0d]", i), 32'(bus.dout_valid), 32'd0);
      check($sformatf("arst_nodone[%0d]", i), 32'(bus.done), 32'd0);
    end

    // Entry (3,2) rewritten to AA while beat (0,1) is presented
`ifdef MEM_BANK_READER_SNAPSHOT_EN
    last_exp = 8'h32;
`else
    last_exp = 8'hAA;
`endif
    pulse_start();
    for (k = 0; k < N; k++) begin
      check_beat(k, (k == N-1) ? last_exp : exp_data(k));
      if (k == 1) bus.mem_flat[(3*COLS + 2)*DW +: DW] = 8'hAA;
      tick();
    end
    check("wr_done", 32'(bus.done), 32'd1);
    tick();
    fill_bank();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end
endmodule
